// File: rtl/tdm_demux_four.sv
// rtl/tdm_demux_four.sv - four-slot TDM receiver: frame alignment, slot demux, coherent frame publish
module tdm_demux_four #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sync,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] Q0,
  output logic [WIDTH-1:0] Q1,
  output logic [WIDTH-1:0] Q2,
  output logic [WIDTH-1:0] Q3,
  output logic             frame_valid,
  output logic             locked,
  output logic [1:0]       slot,
  output logic             sync_err
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state, state_d;
  logic [1:0]       slot_d;
  logic [WIDTH-1:0] sh0, sh1, sh2;
  logic [WIDTH-1:0] sh0_d, sh1_d, sh2_d;
  logic [WIDTH-1:0] q0_d, q1_d, q2_d, q3_d;
  logic             fv_d, se_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      slot        <= 2'd0;
      sh0         <= '0;
      sh1         <= '0;
      sh2         <= '0;
      Q0          <= '0;
      Q1          <= '0;
      Q2          <= '0;
      Q3          <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state       <= state_d;
      slot        <= slot_d;
      sh0         <= sh0_d;
      sh1         <= sh1_d;
      sh2         <= sh2_d;
      Q0          <= q0_d;
      Q1          <= q1_d;
      Q2          <= q2_d;
      Q3          <= q3_d;
      frame_valid <= fv_d;
      sync_err    <= se_d;
    end
  end

  always_comb begin
    state_d = state;
    slot_d  = slot;
    sh0_d   = sh0;
    sh1_d   = sh1;
    sh2_d   = sh2;
    q0_d    = Q0;
    q1_d    = Q1;
    q2_d    = Q2;
    q3_d    = Q3;
    fv_d    = 1'b0;
    se_d    = 1'b0;
    if (in_valid) begin
      case (state)
        HUNT: begin
          if (in_sync) begin
            sh0_d   = in_data;
            slot_d  = 2'd1;
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (in_sync) begin
            // An early sync restarts the frame on this beat rather than dropping lock
            se_d   = (slot != 2'd0);
            sh0_d  = in_data;
            slot_d = 2'd1;
          end else begin
            case (slot)
              2'd0: begin
                se_d    = 1'b1;
                state_d = HUNT;
                slot_d  = 2'd0;
              end
              2'd1: begin
                sh1_d  = in_data;
                slot_d = 2'd2;
              end
              2'd2: begin
                sh2_d  = in_data;
                slot_d = 2'd3;
              end
              default: begin
                q0_d   = sh0;
                q1_d   = sh1;
                q2_d   = sh2;
                q3_d   = in_data;
                fv_d   = 1'b1;
                slot_d = 2'd0;
              end
            endcase
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux_four.sv
// tb/tb_tdm_demux_four.sv - self-checking bench for tdm_demux_four against a queue-based frame model
module tb_tdm_demux_four;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_sync = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [7:0] Q0, Q1, Q2, Q3;
  logic       frame_valid, locked, sync_err;
  logic [1:0] slot;

  tdm_demux_four #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sync(in_sync), .in_data(in_data),
    .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3),
    .frame_valid(frame_valid), .locked(locked), .slot(slot), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the frame in progress is a queue of words; a frame is published once it holds four
  logic [7:0] m_q [4];
  logic [7:0] m_part [$];
  bit         m_locked, m_fv, m_se;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) m_q[i] = 8'h00;
      m_part.delete();
      m_locked = 0;
      m_fv = 0;
      m_se = 0;
    end else begin
      m_fv = 0;
      m_se = 0;
      if (in_valid) begin
        if (in_sync) begin
          if (m_locked && m_part.size() != 0) m_se = 1;
          m_part.delete();
          m_part.push_back(in_data);
          m_locked = 1;
        end else if (m_locked) begin
          if (m_part.size() == 0) begin
            m_se = 1;
            m_locked = 0;
          end else begin
            m_part.push_back(in_data);
            if (m_part.size() == 4) begin
              for (int i = 0; i < 4; i++) m_q[i] = m_part[i];
              m_fv = 1;
              m_part.delete();
            end
          end
        end
      end
    end
  end

  int cyc = 0;
  int fv_cnt = 0;
  int se_cnt = 0;
  int fv_last = 0;
  int fv_prev = 0;

  always @(negedge clk) begin
    int exp_slot;
    cyc++;
    exp_slot = m_part.size() % 4;
    chk("q0", 32'(Q0), 32'(m_q[0]));
    chk("q1", 32'(Q1), 32'(m_q[1]));
    chk("q2", 32'(Q2), 32'(m_q[2]));
    chk("q3", 32'(Q3), 32'(m_q[3]));
    chk("frame_valid", 32'(frame_valid), 32'(m_fv));
    chk("sync_err", 32'(sync_err), 32'(m_se));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("slot", 32'(slot), 32'(exp_slot));
    if (frame_valid) begin
      fv_cnt++;
      fv_prev = fv_last;
      fv_last = cyc;
    end
    if (sync_err) se_cnt++;
  end

  task automatic beat(input bit s, input logic [7:0] d);
    @(negedge clk);
    #1;
    in_valid = 1'b1;
    in_sync  = s;
    in_data  = d;
  endtask

  task automatic idle();
    @(negedge clk);
    #1;
    in_valid = 1'b0;
    in_sync  = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic chk_q(input string name, input logic [31:0] exp);
    chk(name, {Q0, Q1, Q2, Q3}, exp);
  endtask

  initial begin
    int fv0, se0;
    repeat (2) @(negedge clk);
    #1;
    chk_q("reset_q", 32'h0);
    chk("reset_locked", 32'(locked), 32'd0);
    chk("reset_slot", 32'(slot), 32'd0);
    chk("reset_fv", 32'(frame_valid), 32'd0);
    rst = 1'b0;

    // 1: single frame
    fv0 = fv_cnt;
    beat(1, 8'hA1); beat(0, 8'h22); beat(0, 8'h33);
    beat(0, 8'h44);
    idle();
    chk("t1_fv_now", 32'(frame_valid), 32'd1);
    chk_q("t1_q", 32'hA1223344);
    chk("t1_locked", 32'(locked), 32'd1);
    idle();
    chk("t1_fv_count", 32'(fv_cnt - fv0), 32'd1);

    // 2: back-to-back frames
    fv0 = fv_cnt;
    beat(1, 8'h11); beat(0, 8'h12); beat(0, 8'h13); beat(0, 8'h14);
    beat(1, 8'h21); beat(0, 8'h22); beat(0, 8'h23); beat(0, 8'h24);
    idle(); idle();
    chk("t2_fv_count", 32'(fv_cnt - fv0), 32'd2);
    chk("t2_spacing", 32'(fv_last - fv_prev), 32'd4);
    chk_q("t2_q", 32'h21222324);

    // 3: gaps inside a frame
    fv0 = fv_cnt;
    beat(1, 8'h05); idle(); idle(); beat(0, 8'h06); idle(); beat(0, 8'h07); idle(); idle();
    chk("t3_no_early_fv", 32'(fv_cnt - fv0), 32'd0);
    beat(0, 8'h08);
    idle(); idle();
    chk("t3_fv_count", 32'(fv_cnt - fv0), 32'd1);
    chk_q("t3_q", 32'h05060708);

    // 4: early sync restarts the frame
    se0 = se_cnt;
    beat(1, 8'h10); beat(0, 8'h20);
    beat(1, 8'h30); beat(0, 8'h40); beat(0, 8'h50);
    idle();
    chk_q("t4_q_held", 32'h05060708);
    chk("t4_se_count", 32'(se_cnt - se0), 32'd1);
    beat(0, 8'h60);
    idle(); idle();
    chk_q("t4_q", 32'h30405060);

    // 5: missing sync at slot 0 drops lock
    se0 = se_cnt;
    beat(0, 8'h77);
    idle();
    chk("t5_se_now", 32'(sync_err), 32'd1);
    chk("t5_locked", 32'(locked), 32'd0);
    beat(0, 8'h11); beat(0, 8'h22); beat(0, 8'h33); beat(0, 8'h44);
    idle(); idle();
    chk_q("t5_q", 32'h30405060);
    chk("t5_se_count", 32'(se_cnt - se0), 32'd1);
    chk("t5_still_hunt", 32'(locked), 32'd0);

    // 6: asynchronous reset mid-frame
    beat(1, 8'h01); beat(0, 8'h02);
    idle();
    #1 rst = 1'b1;
    #1;
    chk_q("t6_q", 32'h0);
    chk("t6_locked", 32'(locked), 32'd0);
    chk("t6_slot", 32'(slot), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    fv0 = fv_cnt;
    beat(0, 8'h03); beat(0, 8'h04); beat(0, 8'h05); beat(0, 8'h06);
    idle(); idle();
    chk("t6_no_fv", 32'(fv_cnt - fv0), 32'd0);

    // Randomized traffic, mostly well-formed frames with occasional bad syncs and one reset
    for (int i = 0; i < 600; i++) begin
      bit v, s;
      v = ($urandom % 100) < 75;
      if (m_part.size() == 0) s = ($urandom % 100) < 85;
      else s = ($urandom % 100) < 6;
      @(negedge clk);
      #1;
      in_valid = v;
      in_sync  = s;
      in_data  = 8'($urandom);
      if (i == 300) begin
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
      end
    end
    idle(); idle();
    chk("rand_frames_seen", 32'(fv_cnt > 10), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
